// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: stall patterns, exception constants and controller FSM states
package pipe_stall_ctrl_pkg;
    typedef logic [5:0] stall_t;
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID = 6'b000111;
    localparam stall_t STALL_EX = 6'b001111;
    localparam logic [31:0] EXC_ERET = 32'h0000000e;
    localparam logic [31:0] EXC_VECTOR = 32'h00000020;
    typedef enum logic [0:0] {IDLE = 1'b0, MC_HOLD = 1'b1} ctrl_state_t;
endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// sat_counter: free-running up counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr) q <= '0;
        else if (en && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: arbitrates ID/EX stall requests, exception flush and multi-cycle EX holds
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 4,
    parameter int PERF_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_from_id,
    input  logic                stallreq_from_ex,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic [31:0]         excepttype,
    input  logic [31:0]         cp0_epc,
    output stall_t              stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                ex_mc_done,
    output logic                ex_mc_busy,
    output logic [PERF_W-1:0]   stall_cycles
);
    ctrl_state_t state, state_nxt;
    logic [MC_CNT_W-1:0] cnt, cnt_nxt;
    logic exc, hold, mc_go, last;
    // The start cycle itself is the first stalled cycle, so MC_HOLD covers the remaining N-1
    always_comb begin
        exc = !rst && excepttype != '0;
        hold = state == MC_HOLD;
        mc_go = !hold && ex_mc_start && ex_mc_cycles != '0;
        last = hold ? cnt == MC_CNT_W'(1) : mc_go && ex_mc_cycles == MC_CNT_W'(1);
        flush = exc;
        new_pc = !exc ? '0 : excepttype == EXC_ERET ? cp0_epc : EXC_VECTOR;
        stall = (rst || exc) ? STALL_NONE
              : (hold || mc_go || stallreq_from_ex) ? STALL_EX
              : stallreq_from_id ? STALL_ID : STALL_NONE;
        ex_mc_done = !rst && !exc && last;
        ex_mc_busy = !rst && hold;
        state_nxt = exc ? IDLE : hold ? (last ? IDLE : MC_HOLD) : (mc_go && !last) ? MC_HOLD : IDLE;
        cnt_nxt = exc ? '0 : hold ? cnt - 1'b1 : (mc_go && !last) ? ex_mc_cycles - 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end
    sat_counter #(.W(PERF_W)) u_perf (
        .clk(clk),
        .clr(rst),
        .en (stall != STALL_NONE),
        .q  (stall_cycles)
    );
    a_no_restart: assert property (@(posedge clk) disable iff (rst) !(ex_mc_start && state == MC_HOLD));
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vector table, saturation run and randomized check vs a hold-length model
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst, id_req, ex_req, mc_start;
    logic [3:0] mc_cycles;
    logic [31:0] exc_type, epc;
    logic [5:0] stall, stall_s;
    logic flush, flush_s, done, done_s, busy, busy_s;
    logic [31:0] new_pc, new_pc_s, perf;
    logic [3:0] perf_s;
    int total = 0, bad = 0;
    int hold_left = 0, count = 0;
    logic [5:0] e_stall;
    logic e_flush, e_done, e_busy;
    logic [31:0] e_pc;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk(clk), .rst(rst), .stallreq_from_id(id_req), .stallreq_from_ex(ex_req),
        .ex_mc_start(mc_start), .ex_mc_cycles(mc_cycles), .excepttype(exc_type), .cp0_epc(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_done(done), .ex_mc_busy(busy),
        .stall_cycles(perf)
    );
    pipe_stall_ctrl #(.PERF_W(4)) dut_s (
        .clk(clk), .rst(rst), .stallreq_from_id(id_req), .stallreq_from_ex(ex_req),
        .ex_mc_start(mc_start), .ex_mc_cycles(mc_cycles), .excepttype(exc_type), .cp0_epc(epc),
        .stall(stall_s), .flush(flush_s), .new_pc(new_pc_s), .ex_mc_done(done_s), .ex_mc_busy(busy_s),
        .stall_cycles(perf_s)
    );

    typedef struct {
        logic r, id, ex, st;
        logic [3:0] cy;
        logic [31:0] exc, pcin;
        logic [5:0] s;
        logic f;
        logic [31:0] pc;
        logic d, b;
        int c;
    } vec_t;
    vec_t vec [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic i, input logic x, input logic s,
                         input logic [3:0] c, input logic [31:0] e, input logic [31:0] p);
        rst = r; id_req = i; ex_req = x; mc_start = s; mc_cycles = c; exc_type = e; epc = p;
    endtask

    // Model: hold_left = stalled EX cycles still owed after the current one
    task automatic model_eval();
        int remaining;
        e_stall = 6'b0; e_flush = 0; e_pc = 0; e_done = 0; e_busy = 0;
        if (!rst) begin
            e_busy = hold_left > 0;
            if (exc_type != 0) begin
                e_flush = 1;
                e_pc = exc_type == 32'he ? epc : 32'h20;
            end else begin
                remaining = hold_left > 0 ? hold_left : (mc_start ? int'(mc_cycles) : 0);
                e_stall = (remaining > 0 || ex_req) ? 6'b001111 : id_req ? 6'b000111 : 6'b0;
                e_done = remaining == 1;
            end
        end
    endtask

    task automatic model_step();
        int remaining;
        remaining = hold_left > 0 ? hold_left : (mc_start ? int'(mc_cycles) : 0);
        if (rst) count = 0;
        else if (e_stall != 0) count++;
        hold_left = (rst || exc_type != 0 || remaining == 0) ? 0 : remaining - 1;
    endtask

    task automatic check_all(input string tag);
        model_eval();
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
        chk({tag, ".new_pc"}, new_pc, e_pc);
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".perf"}, perf, 32'(count));
        chk({tag, ".perf4"}, 32'(perf_s), 32'(count > 15 ? 15 : count));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        vec[0]  = '{1,1,1,1,4'd3,32'he,32'h1234,6'b000000,0,32'h0,0,0,0};
        vec[1]  = '{1,1,1,1,4'd3,32'he,32'h1234,6'b000000,0,32'h0,0,0,0};
        vec[2]  = '{0,0,0,0,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,0};
        vec[3]  = '{0,1,0,0,4'd0,32'h0,32'h0,6'b000111,0,32'h0,0,0,0};
        vec[4]  = '{0,0,0,0,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,1};
        vec[5]  = '{0,0,0,1,4'd3,32'h0,32'h0,6'b001111,0,32'h0,0,0,1};
        vec[6]  = '{0,0,0,0,4'd0,32'h0,32'h0,6'b001111,0,32'h0,0,1,2};
        vec[7]  = '{0,0,0,0,4'd0,32'h0,32'h0,6'b001111,0,32'h0,1,1,3};
        vec[8]  = '{0,0,0,0,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,4};
        vec[9]  = '{0,1,1,0,4'd0,32'h0,32'h0,6'b001111,0,32'h0,0,0,4};
        vec[10] = '{0,0,0,1,4'd5,32'h0,32'h0,6'b001111,0,32'h0,0,0,5};
        vec[11] = '{0,0,0,0,4'd0,32'he,32'h00400100,6'b000000,1,32'h00400100,0,1,6};
        vec[12] = '{0,0,0,0,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,6};
        vec[13] = '{0,0,0,1,4'd5,32'h0,32'h0,6'b001111,0,32'h0,0,0,6};
        vec[14] = '{0,0,0,0,4'd0,32'h1,32'h00400100,6'b000000,1,32'h20,0,1,7};
        vec[15] = '{0,0,0,0,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,7};
        vec[16] = '{0,0,0,1,4'd1,32'h0,32'h0,6'b001111,0,32'h0,1,0,7};
        vec[17] = '{0,0,0,0,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,8};
        vec[18] = '{0,0,0,1,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,8};
        vec[19] = '{0,1,0,1,4'd0,32'h0,32'h0,6'b000111,0,32'h0,0,0,8};
        vec[20] = '{0,0,0,0,4'd0,32'h0,32'h0,6'b000000,0,32'h0,0,0,9};
        drive(1,0,0,0,0,0,0);
        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            drive(vec[i].r, vec[i].id, vec[i].ex, vec[i].st, vec[i].cy, vec[i].exc, vec[i].pcin);
            #1;
            chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vec[i].s));
            chk($sformatf("v%0d.flush", i), 32'(flush), 32'(vec[i].f));
            chk($sformatf("v%0d.new_pc", i), new_pc, vec[i].pc);
            chk($sformatf("v%0d.done", i), 32'(done), 32'(vec[i].d));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vec[i].b));
            chk($sformatf("v%0d.perf", i), perf, 32'(vec[i].c));
            chk($sformatf("v%0d.perf4", i), 32'(perf_s), 32'(vec[i].c));
            @(negedge clk);
        end
        drive(0,0,1,0,0,0,0);
        repeat (20) @(negedge clk);
        drive(0,0,0,0,0,0,0);
        #1;
        chk("sat.perf4", 32'(perf_s), 32'hf);
        chk("sat.perf32", perf, 32'd29);
        drive(1,0,0,0,0,0,0);
        hold_left = 0;
        count = 0;
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  hold_left == 0 && $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 15) != 0 ? 32'h0 : ($urandom_range(0, 1) ? 32'he : 32'($urandom_range(1, 255))),
                  $urandom);
            #1;
            check_all($sformatf("r%0d", n));
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
